// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target exposing a byte-wide register file with pointer auto-increment
//
// Purpose:
//   Answers to SLAVE_ADDR on a shared SDA/SCL pair (behind external tristate
//   buffers). A master write sets a register pointer, then either writes bytes
//   (pointer auto-increments) or, after a (repeated) START with R/W=1, reads
//   bytes starting at the pointer. On-chip logic sees every master write via
//   wr_strobe/wr_addr/wr_data and can read any register through loc_addr/loc_data.
//   The internal clock must run at least 16x the SCL frequency.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   SCL_i      in   sampled SCL line
//   SDA_i      in   sampled SDA line
//   SDA_t      out  1 = SDA released (high-Z), 0 = drive SDA_o
//   SDA_o      out  drive value, always 0 (open-drain)
//   busy       out  high from address match until STOP, NACK or next START
//   wr_strobe  out  one-clock pulse per register byte written by the master
//   wr_addr    out  register index of that write
//   wr_data    out  byte written
//   loc_addr   in   local read index
//   loc_data   out  regs[loc_addr], combinational

`timescale 1ns/1ps

module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  SCL_i,
  input  logic                  SDA_i,
  output logic                  SDA_t,
  output logic                  SDA_o,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [DEPTH_LOG2-1:0] wr_addr,
  output logic [7:0]            wr_data,
  input  logic [DEPTH_LOG2-1:0] loc_addr,
  output logic [7:0]            loc_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACK,
    S_PTR,
    S_WDATA,
    S_RDATA,
    S_RACK
  } state_t;

  // Input synchronizers: stage 2 is the synchronized value, stage 3 is its
  // previous value for edge detection. Reset to 1 so an idle bus after reset
  // never looks like an edge.
  logic scl_s1, scl_s2, scl_s3;
  logic sda_s1, sda_s2, sda_s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_s3 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_s3 <= 1'b1;
    end else begin
      scl_s1 <= SCL_i;
      scl_s2 <= scl_s1;
      scl_s3 <= scl_s2;
      sda_s1 <= SDA_i;
      sda_s2 <= sda_s1;
      sda_s3 <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s2 & ~scl_s3;
  assign scl_fall = ~scl_s2 & scl_s3;
  assign start_ev = scl_s2 & sda_s3 & ~sda_s2;
  assign stop_ev  = scl_s2 & ~sda_s3 & sda_s2;

  state_t                state;
  state_t                ack_next;   // where to go once the ACK bit is released
  logic                  ack_held;   // ACK currently driven, waiting for its closing fall
  logic [3:0]            bit_cnt;
  logic [7:0]            shreg;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [7:0]            regs [DEPTH];

  // Byte as it stands after the current rising-edge sample.
  logic [7:0] rx_byte;
  assign rx_byte = {shreg[6:0], sda_s2};

  assign SDA_o    = 1'b0;
  assign loc_data = regs[loc_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ack_next  <= S_IDLE;
      ack_held  <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      ptr       <= '0;
      SDA_t     <= 1'b1;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= 8'd0;
      end
    end else begin
      wr_strobe <= 1'b0;

      // Bus conditions win over bit handling and release SDA at once, so a
      // START/STOP during our ACK or read drive never fights the master.
      if (start_ev) begin
        state    <= S_ADDR;
        bit_cnt  <= 4'd0;
        ack_held <= 1'b0;
        SDA_t    <= 1'b1;
        busy     <= 1'b0;
      end else if (stop_ev) begin
        state    <= S_IDLE;
        ack_held <= 1'b0;
        SDA_t    <= 1'b1;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            SDA_t <= 1'b1;
          end

          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                case (state)
                  S_ADDR: begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                      state    <= S_ACK;
                      busy     <= 1'b1;
                      ack_next <= rx_byte[0] ? S_RDATA : S_PTR;
                    end else begin
                      state <= S_IDLE;
                    end
                  end
                  S_PTR: begin
                    ptr      <= rx_byte[DEPTH_LOG2-1:0];
                    state    <= S_ACK;
                    ack_next <= S_WDATA;
                  end
                  default: begin
                    regs[ptr] <= rx_byte;
                    wr_strobe <= 1'b1;
                    wr_addr   <= ptr;
                    wr_data   <= rx_byte;
                    ptr       <= ptr + 1'b1;
                    state     <= S_ACK;
                    ack_next  <= S_WDATA;
                  end
                endcase
              end
            end
          end

          // First fall after the 8th bit pulls SDA low; the next fall ends the
          // ACK slot. For a read, that same fall already presents data bit 7.
          S_ACK: begin
            if (scl_fall) begin
              if (!ack_held) begin
                SDA_t    <= 1'b0;
                ack_held <= 1'b1;
              end else begin
                ack_held <= 1'b0;
                state    <= ack_next;
                if (ack_next == S_RDATA) begin
                  SDA_t   <= regs[ptr][7];
                  shreg   <= {regs[ptr][6:0], 1'b1};
                  bit_cnt <= 4'd1;
                end else begin
                  SDA_t   <= 1'b1;
                  bit_cnt <= 4'd0;
                end
              end
            end
          end

          // bit_cnt counts bits already presented; the fall after bit 0 hands
          // SDA back to the master for its ACK/NACK.
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                SDA_t   <= 1'b1;
                ptr     <= ptr + 1'b1;
                bit_cnt <= 4'd0;
                state   <= S_RACK;
              end else begin
                SDA_t   <= shreg[7];
                shreg   <= {shreg[6:0], 1'b1};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_RACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                state   <= S_RDATA;
                shreg   <= regs[ptr];
                bit_cnt <= 4'd0;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: begin
            state <= S_IDLE;
            SDA_t <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for the I2C master used by the UART bridge; sits on the same SDA/SCL pair behind the tristate buffers.
- Exposes a small byte-wide register file: the master writes a register pointer, then writes or reads bytes with pointer auto-increment.
- A local read port and a write-event strobe connect the register file to on-chip logic.
- Internal clock must be at least 16x the SCL frequency.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit I2C address this target answers to.
- DEPTH_LOG2, 4, log2 of register-file depth (16 bytes).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- SCL_i  input  1  sampled SCL line.
- SDA_i  input  1  sampled SDA line.
- SDA_t  output  1  1 = SDA released (high-Z); 0 = drive SDA_o.
- SDA_o  output  1  drive value; constant 0 (open-drain).
- busy  output  1  high from address match until STOP or next START.
- wr_strobe  output  1  one-clock pulse per register byte written by the master.
- wr_addr  output  DEPTH_LOG2  register index of the write.
- wr_data  output  8  byte written.
- loc_addr  input  DEPTH_LOG2  local read index.
- loc_data  output  8  regs[loc_addr], combinational.

Behaviour:
- Reset values (asynchronous on reset_n low): SDA_t=1, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, pointer=0, all regs=0, state=IDLE.
  - Reset mid-transaction releases SDA immediately.
- Input conditioning:
  - SCL_i and SDA_i each pass through a 2-flop synchronizer; a third flop supplies edge detection.
  - All protocol decisions use the synchronized signals.
- Line events:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - Both are detected in every state and take priority over bit handling in the same clock.
- Bit timing:
  - Receive bits are sampled on the synchronized SCL rising edge, MSB first.
  - SDA_t changes only on the synchronized SCL falling edge, so SDA_t updates 3 clocks after the raw SCL fall.
- States:
  - IDLE: SDA released; wait for START -> ADDR.
  - ADDR: shift 8 bits (7-bit address + R/W).
    - Address match -> ADDR_ACK, busy=1.
    - Mismatch -> IDLE, never ACK.
  - ADDR_ACK: on the next SCL fall, drive SDA low (SDA_t=0) for one SCL period; release on the following fall.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA, loading the shift register with regs[pointer].
  - PTR: receive 8 bits; pointer <= byte[DEPTH_LOG2-1:0] (upper bits ignored); ACK; -> WDATA.
  - WDATA: receive 8 bits, ACK. On the 8th rising edge:
    - regs[pointer] <= byte.
    - wr_strobe pulses 1 clock with wr_addr=pointer, wr_data=byte.
    - pointer <= pointer+1, wrapping modulo 2^DEPTH_LOG2.
  - RDATA: drive bit 7..0 on successive SCL falls (SDA_t = bit value: 0 pulls low, 1 releases); pointer increments after the 8th bit. Then -> RACK with SDA released.
  - RACK: sample master ACK on SCL rise.
    - SDA=0 -> RDATA, loading regs[pointer].
    - SDA=1 (NACK) -> IDLE, busy=0.
- Repeated START in any state -> ADDR; pointer retained, which supports write-pointer-then-read.
- STOP in any state -> IDLE, SDA_t=1, busy=0. Pointer persists across transactions.
- A START/STOP arriving during ACK or read-data drive: release SDA in the same clock the event is detected.
- A master write of a register and a local read of the same index in the same clock: loc_data shows the old value until the following clock.
- Clock stretching is not implemented; SCL is never driven.

Test Plan:
- Write 0x84 (addr 0x42, W), 0x03, 0xA5, 0x5A, STOP:
  - three ACKs.
  - regs[3]=0xA5, regs[4]=0x5A.
  - wr_strobe pulses twice with (3,0xA5), (4,0x5A).
  - loc_addr=4 -> loc_data=0x5A.
- After the previous scenario: 0x84, 0x03, repeated START, 0x85, read two bytes (master ACK then NACK), STOP:
  - SDA carries 0xA5 then 0x5A.
  - SDA_t=1 after the NACK; busy=0 after STOP.
- Address 0x50 (byte 0xA0):
  - no ACK; SDA_t stays 1 through the 9th clock.
  - busy stays 0; following bytes ignored until the next START.
- Pointer 0x0F, write 0x11, 0x22:
  - regs[15]=0x11, regs[0]=0x22; pointer wraps to 0.
- reset_n low while the target is driving an ACK:
  - SDA_t=1 in the same cycle; regs cleared; busy=0.
  - A subsequent valid transaction works normally.
- STOP issued mid-byte during WDATA after 4 bits:
  - no register write, no wr_strobe; state IDLE; SDA released.
